if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 9 +
 rtl/if_stage_if.sv | 12 +
 rtl/if_stage_inst_mem.sv | 14 +
 rtl/if_stage.sv | 36 +++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: word width, NOP, PC increment and ROM image shared by the pipeline stages
package if_stage_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  function automatic logic [WORD_W-1:0] rom_word(input logic [29:0] idx);
    return 32'hA500_0000 ^ {2'b00, idx};
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: redirect/stall controls in, IF/ID register group out
interface if_stage_if;
  import if_stage_pkg::*;
  logic freeze;
  logic branch_taken;
  logic [WORD_W-1:0] branch_addr;
  logic [WORD_W-1:0] pc_out;
  logic [WORD_W-1:0] instruction;
  logic valid;
  modport master(output freeze, branch_taken, branch_addr, input pc_out, instruction, valid);
  modport slave(input freeze, branch_taken, branch_addr, output pc_out, instruction, valid);
endinterface

// File: rtl/if_stage_inst_mem.sv
// inst_mem: constant word-addressed instruction ROM, NOP beyond MEM_DEPTH
module inst_mem
  import if_stage_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter logic [WORD_W-1:0] NOP_WORD = if_stage_pkg::NOP_WORD
) (
  input  logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] data
);
  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];
  assign data = ({2'b00, addr[31:2]} < 32'(MEM_DEPTH)) ? rom_word(addr[31:2]) : NOP_WORD;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, ROM fetch and IF/ID register with branch bubble and freeze
module if_stage
  import if_stage_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_WORD = if_stage_pkg::NOP_WORD
) (
  input logic clk,
  input logic rst,
  if_stage_if.slave bus
);
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] rom_data;
  assign pc_next = pc + PC_INC;
  inst_mem #(.MEM_DEPTH(MEM_DEPTH), .NOP_WORD(NOP_WORD)) u_mem (.addr(pc), .data(rom_data));
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      bus.pc_out <= '0;
      bus.instruction <= NOP_WORD;
      bus.valid <= 1'b0;
    end else if (bus.branch_taken) begin
      pc <= bus.branch_addr;
      bus.pc_out <= '0;
      bus.instruction <= NOP_WORD;
      bus.valid <= 1'b0;
    end else if (!bus.freeze) begin
      pc <= pc_next;
      bus.pc_out <= pc_next;
      bus.instruction <= rom_data;
      bus.valid <= 1'b1;
    end
  end
endmodule
